// File: rtl/qc_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : qc_row_accumulator
// Description : XOR-accumulates rotated Z-bit sub-blocks over one QC-LDPC
//               base-matrix row and queues the finished row word in a small
//               output FIFO (valid/ready). Input is never stalled; a row that
//               finds the FIFO full is dropped and flagged in a sticky bit.
// Revision    : 1.0 - initial release
// ============================================================================
module qc_row_accumulator #(
    parameter int MAXZ       = 81,
    parameter int ROW_W      = 4,
    parameter int CNT_W      = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic [$clog2(MAXZ+1)-1:0]  z_size,
    input  logic                       valid_in,
    input  logic [MAXZ-1:0]            in_data,
    input  logic                       last_in,
    input  logic [ROW_W-1:0]           row_in,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [MAXZ-1:0]            out_data,
    output logic [ROW_W-1:0]           out_row,
    output logic [CNT_W-1:0]           out_count,
    output logic                       busy,
    output logic                       overflow
);

    localparam int ZW    = $clog2(MAXZ + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [ZW-1:0]    C_ZMAX    = ZW'(MAXZ);
    localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [OCC_W-1:0] C_FULL    = OCC_W'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_ACCUM = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [MAXZ-1:0]    r_acc;
    logic [MAXZ-1:0]    r_mask;
    logic [ROW_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_cnt;

    logic [MAXZ-1:0]    r_mem_data [FIFO_DEPTH];
    logic [ROW_W-1:0]   r_mem_row  [FIFO_DEPTH];
    logic [CNT_W-1:0]   r_mem_cnt  [FIFO_DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [OCC_W-1:0]   r_occ;
    logic               r_overflow;

    logic [ZW-1:0]      w_z;
    logic [MAXZ-1:0]    w_mask;
    logic [MAXZ-1:0]    w_new_masked;
    logic [MAXZ-1:0]    w_row_masked;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_push;
    logic [MAXZ-1:0]    w_push_data;
    logic [ROW_W-1:0]   w_push_row;
    logic [CNT_W-1:0]   w_push_cnt;
    logic               w_pop;
    logic               w_full;
    logic               w_push_ok;

    // Effective lifting size and the keep-mask it implies (out-of-range -> MAXZ)
    always_comb begin
        w_z    = ((z_size == '0) || (z_size > C_ZMAX)) ? C_ZMAX : z_size;
        w_mask = '0;
        for (int i = 0; i < MAXZ; i++) begin
            w_mask[i] = (ZW'(i) < w_z);
        end
    end

    // First block of a row uses the live mask; later blocks use the latched one
    assign w_new_masked = in_data & w_mask;
    assign w_row_masked = in_data & r_mask;
    assign w_cnt_inc    = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + CNT_W'(1);

    // Next-state and row-completion (FIFO push request) decode
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_data = '0;
        w_push_row  = '0;
        w_push_cnt  = '0;
        case (r_state)
            S_IDLE: begin
                if (valid_in && last_in) begin
                    w_push      = 1'b1;
                    w_push_data = w_new_masked;
                    w_push_row  = row_in;
                    w_push_cnt  = CNT_W'(1);
                end else if (valid_in) begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (valid_in && last_in) begin
                    w_push      = 1'b1;
                    w_push_data = r_acc ^ w_row_masked;
                    w_push_row  = r_row;
                    w_push_cnt  = w_cnt_inc;
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Partial-row accumulator, latched row context and block counter
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_mask <= '0;
            r_row  <= '0;
            r_cnt  <= '0;
        end else if (valid_in) begin
            if (r_state == S_IDLE) begin
                if (!last_in) begin
                    r_acc  <= w_new_masked;
                    r_mask <= w_mask;
                    r_row  <= row_in;
                    r_cnt  <= CNT_W'(1);
                end
            end else if (last_in) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else begin
                r_acc <= r_acc ^ w_row_masked;
                r_cnt <= w_cnt_inc;
            end
        end
    end

    // A full FIFO still takes a push when the head leaves in the same cycle
    assign w_full    = (r_occ == C_FULL);
    assign valid_out = (r_occ != '0);
    assign w_pop     = valid_out && ready_in;
    assign w_push_ok = w_push && (!w_full || w_pop);

    // Output FIFO storage, pointers, occupancy and sticky drop flag
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem_data[i] <= '0;
                r_mem_row[i]  <= '0;
                r_mem_cnt[i]  <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wr_ptr] <= w_push_data;
                r_mem_row[r_wr_ptr]  <= w_push_row;
                r_mem_cnt[r_wr_ptr]  <= w_push_cnt;
                r_wr_ptr             <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push_ok && !w_pop) begin
                r_occ <= r_occ + OCC_W'(1);
            end else if (w_pop && !w_push_ok) begin
                r_occ <= r_occ - OCC_W'(1);
            end
            if (w_push && !w_push_ok) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign out_data  = r_mem_data[r_rd_ptr];
    assign out_row   = r_mem_row[r_rd_ptr];
    assign out_count = r_mem_cnt[r_rd_ptr];
    assign busy      = (r_state == S_ACCUM);
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_qc_row_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_qc_row_accumulator
// Description : Directed and random self-checking bench for qc_row_accumulator
//               (MAXZ=16) against a queue-based row/FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qc_row_accumulator;

    localparam int MAXZ = 16;
    localparam int ZW   = 5;

    logic            CLK = 1'b0;
    logic            rst_n;
    logic [ZW-1:0]   z_size;
    logic            valid_in;
    logic [MAXZ-1:0] in_data;
    logic            last_in;
    logic [3:0]      row_in;
    logic            valid_out;
    logic            ready_in;
    logic [MAXZ-1:0] out_data;
    logic [3:0]      out_row;
    logic [4:0]      out_count;
    logic            busy;
    logic            overflow;

    qc_row_accumulator #(
        .MAXZ(MAXZ), .ROW_W(4), .CNT_W(5), .FIFO_DEPTH(4)
    ) dut (
        .CLK(CLK), .rst_n(rst_n), .z_size(z_size), .valid_in(valid_in),
        .in_data(in_data), .last_in(last_in), .row_in(row_in),
        .valid_out(valid_out), .ready_in(ready_in), .out_data(out_data),
        .out_row(out_row), .out_count(out_count), .busy(busy),
        .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  r;
        logic [4:0]  c;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mblk[$];
    bit          m_inrow;
    bit          m_ovf;
    logic [15:0] m_mask;
    logic [3:0]  m_row;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] mask_of(input logic [ZW-1:0] zs);
        int z;
        z = (zs == 0 || zs > 16) ? 16 : int'(zs);
        return (z == 16) ? 16'hFFFF : 16'((32'd1 << z) - 1);
    endfunction

    task automatic model_clear();
        mq.delete();
        mblk.delete();
        m_inrow = 0;
        m_ovf   = 0;
    endtask

    task automatic check_all();
        check("valid_out", valid_out, mq.size() != 0);
        check("busy", busy, m_inrow);
        check("overflow", overflow, m_ovf);
        if (mq.size() != 0) begin
            check("out_data", out_data, mq[0].d);
            check("out_row", out_row, mq[0].r);
            check("out_count", out_count, mq[0].c);
        end
    endtask

    // Advance the model with the inputs present at this edge, then clock and compare
    task automatic tick();
        bit          do_pop;
        ent_t        e;
        logic [15:0] x;
        do_pop = (mq.size() != 0) && ready_in;
        if (do_pop) mq.delete(0);
        if (valid_in) begin
            if (!m_inrow) begin
                m_mask = mask_of(z_size);
                m_row  = row_in;
                mblk.delete();
            end
            mblk.push_back(in_data & m_mask);
            if (last_in) begin
                x = '0;
                foreach (mblk[i]) x ^= mblk[i];
                e.d = x;
                e.r = m_row;
                e.c = (mblk.size() > 31) ? 5'd31 : 5'(mblk.size());
                if (mq.size() < 4) mq.push_back(e);
                else m_ovf = 1;
                m_inrow = 0;
                mblk.delete();
            end else begin
                m_inrow = 1;
            end
        end
        @(posedge CLK);
        #1;
        check_all();
    endtask

    task automatic set_in(input bit v, input bit l, input logic [15:0] d, input logic [3:0] r);
        valid_in = v;
        last_in  = l;
        in_data  = d;
        row_in   = r;
    endtask

    task automatic release_reset();
        set_in(0, 0, 16'h0, 4'h0);
        ready_in = 0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        rst_n = 1;
        @(posedge CLK);
        #1;
        model_clear();
        check("rst_valid_out", valid_out, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_row", out_row, 0);
        check("rst_out_count", out_count, 0);
        check("rst_busy", busy, 0);
        check("rst_overflow", overflow, 0);
    endtask

    initial begin
        rst_n    = 0;
        z_size   = 5'd16;
        ready_in = 0;
        set_in(0, 0, 16'h0, 4'h0);
        release_reset();

        // Three-block row
        ready_in = 1;
        set_in(1, 0, 16'h00FF, 4'd3); tick();
        check("busy_after_first", busy, 1);
        set_in(1, 0, 16'h0F0F, 4'd9); tick();
        set_in(1, 1, 16'h3333, 4'd9); tick();
        check("row3_data", out_data, 16'h3CC3);
        check("row3_row", out_row, 4'd3);
        check("row3_count", out_count, 5'd3);
        check("row3_valid", valid_out, 1);
        set_in(0, 0, 16'h0, 4'h0); tick();

        // Single-block row
        set_in(1, 1, 16'hA5A5, 4'd7); tick();
        check("single_data", out_data, 16'hA5A5);
        check("single_count", out_count, 5'd1);
        check("single_busy", busy, 0);
        set_in(0, 0, 16'h0, 4'h0); tick();

        // Masking with z_size=10 then z_size=0, with a mid-row gap
        z_size = 5'd10;
        set_in(1, 0, 16'hFFFF, 4'd2); tick();
        z_size = 5'd0;
        set_in(0, 0, 16'h0, 4'h0); tick(); tick();
        set_in(1, 1, 16'h0001, 4'd2); tick();
        check("mask10_data", out_data, 16'h03FE);
        set_in(1, 0, 16'hFFFF, 4'd4); tick();
        set_in(1, 1, 16'h0001, 4'd4); tick();
        check("mask0_data", out_data, 16'hFFFE);
        set_in(0, 0, 16'h0, 4'h0); tick();

        // Counter saturation over 35 blocks
        z_size = 5'd16;
        for (int i = 1; i <= 35; i++) begin
            set_in(1, i == 35, 16'(i * 16'h0111), 4'd5);
            tick();
        end
        check("sat_count", out_count, 5'd31);
        set_in(0, 0, 16'h0, 4'h0); tick();

        // Overflow: five rows into a stalled four-deep FIFO
        ready_in = 0;
        for (int i = 1; i <= 5; i++) begin
            set_in(1, 1, 16'(i), 4'(i));
            tick();
        end
        check("ovf_set", overflow, 1);
        set_in(0, 0, 16'h0, 4'h0);
        ready_in = 1;
        for (int i = 1; i <= 4; i++) begin
            check("ovf_order", out_data, 16'(i));
            tick();
        end
        check("ovf_drained", valid_out, 0);

        // Full FIFO with simultaneous pop and push
        rst_n = 0;
        release_reset();
        for (int i = 1; i <= 4; i++) begin
            set_in(1, 1, 16'(16'h10 + i), 4'(i));
            tick();
        end
        ready_in = 1;
        set_in(1, 1, 16'h0015, 4'd5); tick();
        check("fullpop_ovf", overflow, 0);
        check("fullpop_head", out_data, 16'h0012);
        set_in(0, 0, 16'h0, 4'h0);
        repeat (4) tick();
        check("fullpop_empty", valid_out, 0);

        // Asynchronous reset in the middle of a row
        set_in(1, 0, 16'h1111, 4'd6); tick();
        set_in(1, 0, 16'h2222, 4'd6); tick();
        #2;
        rst_n = 0;
        #1;
        check("async_busy", busy, 0);
        check("async_valid", valid_out, 0);
        check("async_data", out_data, 0);
        release_reset();
        ready_in = 1;
        set_in(1, 1, 16'h1234, 4'd1); tick();
        check("post_rst_data", out_data, 16'h1234);
        check("post_rst_count", out_count, 5'd1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            valid_in = ($urandom_range(0, 3) != 0);
            last_in  = ($urandom_range(0, 2) == 0);
            in_data  = 16'($urandom);
            row_in   = 4'($urandom);
            z_size   = 5'($urandom_range(0, 20));
            ready_in = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
